// File: rtl/parallel_to_serial_tx.sv
// ---------------------------------------------------------------------------
// parallel_to_serial_tx
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is taken over a
// valid/ready handshake and shifted out one bit per enabled clock on dataOut.
// Per-bit valid and frame start/last markers go with the data. outputEnable
// lets the downstream receiver pause the stream without losing bits.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   parallelIn   in   [WIDTH-1:0] word to send, sampled on accept only
//   loadValid    in   producer has a word on parallelIn
//   loadReady    out  a word can be accepted this cycle
//   outputEnable in   1 = shift this cycle, 0 = hold
//   dataOut      out  serial data bit (IDLE_LEVEL when no frame is active)
//   bitValid     out  dataOut is a real bit and is consumed this cycle
//   frameStart   out  bitValid for the first bit of a frame
//   frameLast    out  bitValid for the last bit of a frame
//   busy         out  a frame is in progress
// ---------------------------------------------------------------------------
module parallel_to_serial_tx #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic             outputEnable,
    output logic             dataOut,
    output logic             bitValid,
    output logic             frameStart,
    output logic             frameLast,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    logic accept;
    logic head_bit;

    // Output decode: everything is combinational from the registers and
    // outputEnable, so a pause takes effect in the same cycle.
    assign busy       = (state_q == SHIFT);
    assign bitValid   = busy & outputEnable;
    assign frameStart = bitValid & (bit_count_q == '0);
    assign frameLast  = bitValid & (bit_count_q == LAST_CNT);

    // Ready while idle, or on the last bit so the next frame follows with no
    // gap. Never looks at loadValid.
    assign loadReady  = (state_q == IDLE) | frameLast;
    assign accept     = loadValid & loadReady;

    assign head_bit   = (MSB_FIRST != 0) ? shift_reg_q[WIDTH-1] : shift_reg_q[0];
    assign dataOut    = busy ? head_bit : IDLE_LEVEL;

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_count_d = bit_count_q;

        if (accept) begin
            // Covers both the idle load and the back-to-back load on frameLast.
            state_d     = SHIFT;
            shift_reg_d = parallelIn;
            bit_count_d = '0;
        end else if (bitValid) begin
            // Move the next bit into the head position; vacated bit fills 0.
            if (MSB_FIRST != 0) begin
                shift_reg_d = {shift_reg_q[WIDTH-2:0], 1'b0};
            end else begin
                shift_reg_d = {1'b0, shift_reg_q[WIDTH-1:1]};
            end

            if (frameLast) begin
                state_d     = IDLE;
                bit_count_d = '0;
            end else begin
                bit_count_d = bit_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_count_q <= bit_count_d;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_parallel_to_serial_tx
//
// Directed bench for parallel_to_serial_tx. Two instances share stimulus:
// dut_m (WIDTH=8, MSB first, idle level 0) and dut_l (WIDTH=8, LSB first,
// idle level 1). Each check compares the packed output vector
// {dataOut, bitValid, frameStart, frameLast, busy, loadReady} against a
// hand-derived value.
// ---------------------------------------------------------------------------
module tb_parallel_to_serial_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] parallelIn;
    logic       loadValid;
    logic       outputEnable;

    logic dout_m, bv_m, fs_m, fl_m, busy_m, lr_m;
    logic dout_l, bv_l, fs_l, fl_l, busy_l, lr_l;

    logic [5:0] obs_m, obs_l;
    assign obs_m = {dout_m, bv_m, fs_m, fl_m, busy_m, lr_m};
    assign obs_l = {dout_l, bv_l, fs_l, fl_l, busy_l, lr_l};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    parallel_to_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_m (
        .clock(clock), .reset(reset), .parallelIn(parallelIn),
        .loadValid(loadValid), .loadReady(lr_m), .outputEnable(outputEnable),
        .dataOut(dout_m), .bitValid(bv_m), .frameStart(fs_m),
        .frameLast(fl_m), .busy(busy_m)
    );

    parallel_to_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_l (
        .clock(clock), .reset(reset), .parallelIn(parallelIn),
        .loadValid(loadValid), .loadReady(lr_l), .outputEnable(outputEnable),
        .dataOut(dout_l), .bitValid(bv_l), .frameStart(fs_l),
        .frameLast(fl_l), .busy(busy_l)
    );

    // Rising edge, then step off it so inputs change away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected vector for a busy cycle carrying bit index i of an 8-bit frame.
    function automatic logic [5:0] bitv(input logic d, input int i, input logic oe);
        logic first, last;
        first = (i == 0);
        last  = (i == 7);
        if (oe) bitv = {d, 1'b1, first, last, 1'b1, last};
        else    bitv = {d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [5:0] obs,
                       input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %b expected %b (dout,bv,fs,fl,busy,rdy)",
                   tag, cyc, obs, exp);
        end
    endtask

    localparam logic [5:0] IDLE_M = 6'b000001;
    localparam logic [5:0] IDLE_L = 6'b100001;

    initial begin
        logic [7:0] w;
        int         i;
        logic       oe;

        reset        = 1'b1;
        parallelIn   = 8'h00;
        loadValid    = 1'b0;
        outputEnable = 1'b1;

        // ---- reset state ----
        tick();
        tick();
        chk("reset_m", 0, obs_m, IDLE_M);
        chk("reset_l", 0, obs_l, IDLE_L);
        reset = 1'b0;
        tick();
        chk("idle_m", 0, obs_m, IDLE_M);
        chk("idle_l", 0, obs_l, IDLE_L);

        // ---- 1 & 2: single frame 8'hB1, both bit orders ----
        w          = 8'hB1;
        parallelIn = w;
        loadValid  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) loadValid = 1'b0;
            #1;
            chk("single_msb", c, obs_m, bitv(w[8-c], c - 1, 1'b1));
            chk("single_lsb", c, obs_l, bitv(w[c-1], c - 1, 1'b1));
        end
        tick();
        chk("single_end_m", 9, obs_m, IDLE_M);
        chk("single_end_l", 9, obs_l, IDLE_L);

        // ---- 3: back-to-back 8'hB1 then 8'h0F ----
        parallelIn = 8'hB1;
        loadValid  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) parallelIn = 8'h0F;
            if (c == 9) loadValid = 1'b0;
            #1;
            w = (c <= 8) ? 8'hB1 : 8'h0F;
            i = (c - 1) % 8;
            chk("b2b_msb", c, obs_m, bitv(w[7-i], i, 1'b1));
        end
        tick();
        chk("b2b_end", 17, obs_m, IDLE_M);

        // ---- 4: pause with outputEnable=0 in cycles 4-5 ----
        w          = 8'hB1;
        parallelIn = w;
        loadValid  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) loadValid = 1'b0;
            oe           = !(c == 4 || c == 5);
            outputEnable = oe;
            #1;
            i = (c <= 3) ? c - 1 : ((c <= 5) ? 3 : c - 3);
            chk("pause_msb", c, obs_m, bitv(w[7-i], i, oe));
        end
        outputEnable = 1'b1;
        tick();
        chk("pause_end", 11, obs_m, IDLE_M);

        // ---- 5: reset mid-frame, then a clean 8'h0F frame ----
        w          = 8'hB1;
        parallelIn = w;
        loadValid  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) loadValid = 1'b0;
            if (c == 4) reset = 1'b1;
            #1;
            chk("prerst_msb", c, obs_m, bitv(w[8-c], c - 1, 1'b1));
        end
        tick();
        reset = 1'b0;
        #1;
        chk("rst_abort_m", 5, obs_m, IDLE_M);
        chk("rst_abort_l", 5, obs_l, IDLE_L);
        w          = 8'h0F;
        parallelIn = w;
        loadValid  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) loadValid = 1'b0;
            #1;
            chk("postrst_msb", c, obs_m, bitv(w[8-c], c - 1, 1'b1));
        end
        tick();
        chk("postrst_end", 9, obs_m, IDLE_M);

        // ---- 6: load attempt while busy, accepted only on frameLast ----
        parallelIn = 8'hB1;
        loadValid  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) loadValid = 1'b0;
            if (c == 3) begin
                parallelIn = 8'hFF;
                loadValid  = 1'b1;
            end
            if (c == 9) loadValid = 1'b0;
            #1;
            w = (c <= 8) ? 8'hB1 : 8'hFF;
            i = (c - 1) % 8;
            chk("busyload_msb", c, obs_m, bitv(w[7-i], i, 1'b1));
        end
        tick();
        chk("busyload_end", 17, obs_m, IDLE_M);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
